// File: rtl/ram_burst_ctrl.sv
// Command-driven burst RAM controller.
// Incoming commands set write/read pointers, write words, or request
// reads. Read data is presented on a valid/ready output holding register.
module ram_burst_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int DATA_W    = 8,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid_i,
    input  logic [DATA_W+1:0] rx_data_i,
    input  logic              tx_ready_i,
    input  logic              clr_err_i,
    output logic              tx_valid_o,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              err_addr_o,
    output logic              err_ovf_o
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    // Depth widened by one bit so any payload value compares without truncation.
    localparam logic [DATA_W:0] DEPTH_EXT = (DATA_W + 1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    localparam logic [1:0] OP_SET_WR = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_SET_RD = 2'b10;
    localparam logic [1:0] OP_READ   = 2'b11;

    // A payload must be able to carry any full address.
    if (DATA_W < ADDR_W) begin : g_width_check
        $error("ram_burst_ctrl: DATA_W must be >= $clog2(MEM_DEPTH)");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                err_addr_q, err_addr_d;
    logic                err_ovf_q, err_ovf_d;
    logic                mem_we;
    logic                rd_accept;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];

    logic [1:0]          opcode;
    logic [DATA_W-1:0]   payload;
    logic [ADDR_W-1:0]   pay_addr;
    logic                pay_in_range;

    assign opcode       = rx_data_i[DATA_W+1:DATA_W];
    assign payload      = rx_data_i[DATA_W-1:0];
    assign pay_addr     = payload[ADDR_W-1:0];
    assign pay_in_range = ({1'b0, payload} < DEPTH_EXT);

    // Post-increment that wraps at the last real word (depth need not be 2^n).
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (a == LAST_ADDR) begin
            return '0;
        end
        return a + 1'b1;
    endfunction

    assign tx_valid_o = (state_q == HOLD);
    assign tx_data_o  = tx_data_q;
    assign err_addr_o = err_addr_q;
    assign err_ovf_o  = err_ovf_q;

    // Command decode, output handshake next-state and sticky error update.
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        rd_addr_d  = rd_addr_q;
        tx_data_d  = tx_data_q;
        err_addr_d = clr_err_i ? 1'b0 : err_addr_q;
        err_ovf_d  = clr_err_i ? 1'b0 : err_ovf_q;
        mem_we     = 1'b0;
        rd_accept  = 1'b0;

        if (rx_valid_i) begin
            case (opcode)
                OP_SET_WR: begin
                    if (pay_in_range) wr_addr_d = pay_addr;
                    else              err_addr_d = 1'b1;
                end
                OP_SET_RD: begin
                    if (pay_in_range) rd_addr_d = pay_addr;
                    else              err_addr_d = 1'b1;
                end
                OP_WRITE: begin
                    mem_we = 1'b1;
                    if (AUTO_INC != 0) wr_addr_d = addr_inc(wr_addr_q);
                end
                OP_READ: begin
                    // A read is only taken if the holding register is free or
                    // being drained this same edge; otherwise it is dropped.
                    if ((state_q == EMPTY) || tx_ready_i) rd_accept = 1'b1;
                    else                                  err_ovf_d = 1'b1;
                end
                default: ;
            endcase
        end

        if (rd_accept) begin
            tx_data_d = mem[rd_addr_q];
            if (AUTO_INC != 0) rd_addr_d = addr_inc(rd_addr_q);
        end

        case (state_q)
            EMPTY:   if (rd_accept) state_d = HOLD;
            HOLD:    if (tx_ready_i && !rd_accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            tx_data_q  <= '0;
            err_addr_q <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            tx_data_q  <= tx_data_d;
            err_addr_q <= err_addr_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

    // Storage array: never cleared, writes suppressed while in reset.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[wr_addr_q] <= payload;
        end
    end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: a vector table on the default
// configuration plus hand sequences for depth 200 and fixed addressing.
`timescale 1ns/1ps
module tb_ram_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid;
    logic [9:0] rx_data;
    logic       tx_ready;
    logic       clr_err;

    logic       tv1, ea1, eo1;
    logic [7:0] td1;
    logic       tv2, ea2, eo2;
    logic [7:0] td2;
    logic       tv3, ea3, eo3;
    logic [7:0] td3;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    ram_burst_ctrl #(.MEM_DEPTH(256), .DATA_W(8), .AUTO_INC(1)) dut (
        .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_ready_i(tx_ready), .clr_err_i(clr_err),
        .tx_valid_o(tv1), .tx_data_o(td1), .err_addr_o(ea1), .err_ovf_o(eo1)
    );

    ram_burst_ctrl #(.MEM_DEPTH(200), .DATA_W(8), .AUTO_INC(1)) dut200 (
        .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_ready_i(tx_ready), .clr_err_i(clr_err),
        .tx_valid_o(tv2), .tx_data_o(td2), .err_addr_o(ea2), .err_ovf_o(eo2)
    );

    ram_burst_ctrl #(.MEM_DEPTH(256), .DATA_W(8), .AUTO_INC(0)) dut_fix (
        .clk(clk), .rst(rst), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_ready_i(tx_ready), .clr_err_i(clr_err),
        .tx_valid_o(tv3), .tx_data_o(td3), .err_addr_o(ea3), .err_ovf_o(eo3)
    );

    typedef struct {
        logic       rst;
        logic       rxv;
        logic [9:0] rx;
        logic       tr;
        logic       clr;
        logic       etv;
        logic [7:0] etd;
        logic       cd;   // 1 = compare tx_data on this row
        logic       eea;
        logic       eeo;
    } vec_t;

    vec_t vt[$];

    task automatic add(input logic r, input logic v, input logic [9:0] d,
                       input logic t, input logic c, input logic etv,
                       input logic [7:0] etd, input logic cd,
                       input logic eea, input logic eeo);
        vec_t x;
        x.rst = r; x.rxv = v; x.rx = d; x.tr = t; x.clr = c;
        x.etv = etv; x.etd = etd; x.cd = cd; x.eea = eea; x.eeo = eeo;
        vt.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Drive one cycle of inputs, then sample just after the edge.
    task automatic step(input logic r, input logic v, input logic [9:0] d,
                        input logic t, input logic c);
        rst = r; rx_valid = v; rx_data = d; tx_ready = t; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0; clr_err = 1'b0;

        //   rst rxv rx     tr clr  etv etd   cd eea eeo
        add(1, 1, 10'h3FF, 0, 0,   0, 8'h00, 1, 0, 0);
        add(1, 1, 10'h3FF, 0, 0,   0, 8'h00, 1, 0, 0);
        add(0, 1, 10'h005, 1, 0,   0, 8'h00, 1, 0, 0);
        add(0, 1, 10'h1AA, 1, 0,   0, 8'h00, 1, 0, 0);
        add(0, 1, 10'h1BB, 1, 0,   0, 8'h00, 1, 0, 0);
        add(0, 1, 10'h205, 1, 0,   0, 8'h00, 1, 0, 0);
        add(0, 1, 10'h300, 1, 0,   1, 8'hAA, 1, 0, 0);
        add(0, 1, 10'h300, 1, 0,   1, 8'hBB, 1, 0, 0);
        add(0, 0, 10'h000, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h0FF, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h111, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h122, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h2FF, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h300, 1, 0,   1, 8'h11, 1, 0, 0);
        add(0, 1, 10'h300, 1, 0,   1, 8'h22, 1, 0, 0);
        add(0, 0, 10'h000, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h001, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h133, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h200, 0, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h300, 0, 0,   1, 8'h22, 1, 0, 0);
        add(0, 1, 10'h144, 0, 0,   1, 8'h22, 1, 0, 0);
        add(0, 1, 10'h300, 0, 0,   1, 8'h22, 1, 0, 1);
        add(0, 0, 10'h000, 1, 0,   0, 8'h00, 0, 0, 1);
        add(0, 0, 10'h000, 0, 1,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h300, 1, 0,   1, 8'h33, 1, 0, 0);
        add(0, 1, 10'h300, 1, 0,   1, 8'h44, 1, 0, 0);
        add(0, 0, 10'h000, 1, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h200, 0, 0,   0, 8'h00, 0, 0, 0);
        add(0, 1, 10'h300, 0, 0,   1, 8'h22, 1, 0, 0);
        add(0, 1, 10'h300, 0, 1,   1, 8'h22, 1, 0, 1);
        add(0, 0, 10'h000, 0, 1,   1, 8'h22, 1, 0, 0);
        add(1, 0, 10'h000, 0, 0,   0, 8'h00, 1, 0, 0);
        add(0, 1, 10'h200, 1, 0,   0, 8'h00, 1, 0, 0);
        add(0, 1, 10'h300, 1, 0,   1, 8'h22, 1, 0, 0);
        add(0, 0, 10'h300, 1, 0,   0, 8'h00, 0, 0, 0);

        foreach (vt[i]) begin
            step(vt[i].rst, vt[i].rxv, vt[i].rx, vt[i].tr, vt[i].clr);
            chk($sformatf("row%0d tx_valid", i), 32'(tv1), 32'(vt[i].etv));
            if (vt[i].cd) chk($sformatf("row%0d tx_data", i), 32'(td1), 32'(vt[i].etd));
            chk($sformatf("row%0d err_addr", i), 32'(ea1), 32'(vt[i].eea));
            chk($sformatf("row%0d err_ovf", i), 32'(eo1), 32'(vt[i].eeo));
        end

        // Depth 200: range errors on both pointer commands, wrap at 199.
        step(1, 0, 10'h000, 1, 0);
        chk("d200 reset err_addr", 32'(ea2), 32'd0);
        step(0, 1, 10'h0C8, 1, 0);
        chk("d200 wr range err", 32'(ea2), 32'd1);
        step(0, 1, 10'h1AB, 1, 0);
        step(0, 1, 10'h200, 1, 0);
        step(0, 1, 10'h300, 1, 0);
        chk("d200 wr_addr kept valid", 32'(tv2), 32'd1);
        chk("d200 wr_addr kept data", 32'(td2), 32'hAB);
        step(0, 1, 10'h0C7, 1, 0);
        step(0, 1, 10'h155, 1, 0);
        step(0, 1, 10'h166, 1, 0);
        step(0, 1, 10'h2C7, 1, 0);
        step(0, 0, 10'h000, 1, 1);
        chk("d200 clr err_addr", 32'(ea2), 32'd0);
        step(0, 1, 10'h2C8, 1, 0);
        chk("d200 rd range err", 32'(ea2), 32'd1);
        step(0, 1, 10'h300, 1, 0);
        chk("d200 mem199", 32'(td2), 32'h55);
        step(0, 1, 10'h300, 1, 0);
        chk("d200 mem0 wrap", 32'(td2), 32'h66);
        chk("d200 tx_valid", 32'(tv2), 32'd1);

        // Fixed addressing: repeated reads of one word, reset drops held data.
        step(1, 0, 10'h000, 1, 0);
        step(0, 1, 10'h003, 1, 0);
        step(0, 1, 10'h177, 1, 0);
        step(0, 1, 10'h203, 1, 0);
        step(0, 1, 10'h300, 1, 0);
        chk("fix read1 valid", 32'(tv3), 32'd1);
        chk("fix read1 data", 32'(td3), 32'h77);
        step(0, 1, 10'h300, 1, 0);
        chk("fix read2 data", 32'(td3), 32'h77);
        step(1, 0, 10'h000, 0, 0);
        chk("fix rst tx_valid", 32'(tv3), 32'd0);
        chk("fix rst tx_data", 32'(td3), 32'h00);
        step(0, 1, 10'h203, 1, 0);
        step(0, 1, 10'h300, 1, 0);
        chk("fix mem kept valid", 32'(tv3), 32'd1);
        chk("fix mem kept data", 32'(td3), 32'h77);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
